// File: rtl/sudoku_grid_loader_if.sv
// Bundles the UART-side byte strobe, the solver-side grid handshake and the
// loader status outputs into one port.
//   master : byte source / grid consumer (drives byte_ready, uart_byte, grid_ack)
//   slave  : the loader (drives grid_valid, grid, cell_count, frame_err, overrun)
interface sudoku_grid_loader_if #(
  parameter int N_CELLS = 81,
  parameter int CELL_W  = 4,
  parameter int IDX_W   = 7
);
  logic                        byte_ready;
  logic [7:0]                  uart_byte;
  logic                        grid_ack;
  logic                        grid_valid;
  logic [N_CELLS*CELL_W-1:0]   grid;
  logic [IDX_W-1:0]            cell_count;
  logic                        frame_err;
  logic                        overrun;

  modport master (
    output byte_ready, uart_byte, grid_ack,
    input  grid_valid, grid, cell_count, frame_err, overrun
  );

  modport slave (
    input  byte_ready, uart_byte, grid_ack,
    output grid_valid, grid, cell_count, frame_err, overrun
  );
endinterface

// File: rtl/sudoku_grid_loader.sv
// Parses ASCII puzzle text arriving from the UART receiver into a packed grid
// of N_CELLS cells (CELL_W bits each, 0 = empty) and offers the completed grid
// to the solver with a valid/ack handshake. Single clock domain.
// Ports:
//   uart_sampling_clk : clock
//   rst               : asynchronous reset, active-high
//   bus (slave)       : byte_ready/uart_byte in, grid_ack in,
//                       grid_valid/grid/cell_count/frame_err/overrun out
// Characters: '1'..'9' give a value, '0' or '.' give an empty cell,
// space/CR/LF/',' are skipped, anything else is a framing error that is
// cleared only by an LF.
module sudoku_grid_loader #(
  parameter int N_CELLS = 81,
  parameter int CELL_W  = 4,
  parameter int IDX_W   = 7
) (
  input  logic                  uart_sampling_clk,
  input  logic                  rst,
  sudoku_grid_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FULL = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic                        r_byte_ready_q;
  logic [N_CELLS*CELL_W-1:0]   r_grid;
  logic [IDX_W-1:0]            r_cell_count;
  logic                        r_grid_valid;
  logic                        r_overrun;

  logic                        w_strb;
  logic                        w_is_cell;
  logic                        w_is_skip;
  logic                        w_is_bad;
  logic                        w_is_lf;
  logic                        w_last;
  logic [7:0]                  w_digit_off;
  logic [CELL_W-1:0]           w_value;

  // A level held for several cycles must count as a single byte.
  assign w_strb = bus.byte_ready & ~r_byte_ready_q;
  assign w_last = (r_cell_count == IDX_W'(N_CELLS - 1));

  // Character classification of the byte on the bus.
  always_comb begin
    w_is_cell   = 1'b0;
    w_is_skip   = 1'b0;
    w_value     = '0;
    w_digit_off = bus.uart_byte - 8'h30;
    if (bus.uart_byte >= 8'h31 && bus.uart_byte <= 8'h39) begin
      w_is_cell = 1'b1;
      w_value   = w_digit_off[CELL_W-1:0];
    end else if (bus.uart_byte == 8'h30 || bus.uart_byte == 8'h2E) begin
      w_is_cell = 1'b1;
    end else if (bus.uart_byte == 8'h20 || bus.uart_byte == 8'h0D ||
                 bus.uart_byte == 8'h0A || bus.uart_byte == 8'h2C) begin
      w_is_skip = 1'b1;
    end
    w_is_bad = ~w_is_cell & ~w_is_skip;
    w_is_lf  = (bus.uart_byte == 8'h0A);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_strb && w_is_cell && w_last) w_next_state = S_FULL;
        else if (w_strb && w_is_bad)       w_next_state = S_ERR;
      end
      S_FULL: begin
        if (bus.grid_ack) w_next_state = S_LOAD;
      end
      S_ERR: begin
        if (w_strb && w_is_lf) w_next_state = S_LOAD;
      end
      default: w_next_state = S_LOAD;
    endcase
  end

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      r_byte_ready_q <= 1'b0;
      r_grid         <= '0;
      r_cell_count   <= '0;
      r_grid_valid   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_byte_ready_q <= bus.byte_ready;
      // Any strobe while full is dropped, even alongside grid_ack.
      r_overrun      <= (r_state == S_FULL) && w_strb;
      case (r_state)
        S_LOAD: begin
          if (w_strb && w_is_cell) begin
            // Decoded write keeps the cell index in range for every count value.
            for (int unsigned k = 0; k < N_CELLS; k++) begin
              if (r_cell_count == IDX_W'(k)) r_grid[k*CELL_W +: CELL_W] <= w_value;
            end
            r_cell_count <= r_cell_count + 1'b1;
            if (w_last) r_grid_valid <= 1'b1;
          end else if (w_strb && w_is_bad) begin
            r_cell_count <= '0;
          end
        end
        S_FULL: begin
          if (bus.grid_ack) begin
            r_grid_valid <= 1'b0;
            r_cell_count <= '0;
          end
        end
        S_ERR: begin
          if (w_strb && w_is_lf) r_cell_count <= '0;
        end
        default: r_cell_count <= '0;
      endcase
    end
  end

  assign bus.grid       = r_grid;
  assign bus.cell_count = r_cell_count;
  assign bus.grid_valid = r_grid_valid;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = (r_state == S_ERR);

endmodule

// File: tb/tb_sudoku_grid_loader.sv
module tb_sudoku_grid_loader;
  localparam int N_CELLS = 81;
  localparam int CELL_W  = 4;
  localparam int IDX_W   = 7;
  localparam int GW      = N_CELLS * CELL_W;

  logic uart_sampling_clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  sudoku_grid_loader_if #(.N_CELLS(N_CELLS), .CELL_W(CELL_W), .IDX_W(IDX_W)) ifc ();

  sudoku_grid_loader #(.N_CELLS(N_CELLS), .CELL_W(CELL_W), .IDX_W(IDX_W)) dut (
    .uart_sampling_clk (uart_sampling_clk),
    .rst               (rst),
    .bus               (ifc.slave)
  );

  always #5 uart_sampling_clk = ~uart_sampling_clk;

  logic [GW-1:0] grid_q [$];   // expected grid for each grid_valid rise
  logic [GW-1:0] ovr_q  [$];   // expected (held) grid for each overrun pulse

  task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grid or an overrun.
  logic prev_valid = 1'b0;
  logic prev_ovr   = 1'b0;
  always @(negedge uart_sampling_clk) begin
    if (ifc.grid_valid && !prev_valid) begin
      if (grid_q.size() == 0) check("unexpected_grid_valid", 1, 0);
      else begin
        check("grid_content", ifc.grid, grid_q.pop_front());
        check("grid_count81", GW'(ifc.cell_count), GW'(N_CELLS));
      end
    end
    if (ifc.overrun) begin
      if (ovr_q.size() == 0) check("unexpected_overrun", 1, 0);
      else begin
        check("overrun_grid_held", ifc.grid, ovr_q.pop_front());
        check("overrun_one_cycle", GW'(prev_ovr), 0);
      end
    end
    prev_valid = ifc.grid_valid;
    prev_ovr   = ifc.overrun;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge uart_sampling_clk);
    ifc.uart_byte  = b;
    ifc.byte_ready = 1'b1;
    repeat (hold) @(negedge uart_sampling_clk);
    ifc.byte_ready = 1'b0;
    @(negedge uart_sampling_clk);
  endtask

  task automatic ack();
    @(negedge uart_sampling_clk);
    ifc.grid_ack = 1'b1;
    @(negedge uart_sampling_clk);
    ifc.grid_ack = 1'b0;
  endtask

  logic [GW-1:0] g1, g2, g6;

  initial begin
    ifc.byte_ready = 1'b0;
    ifc.uart_byte  = '0;
    ifc.grid_ack   = 1'b0;
    // Expected grids: g1 cell k = k%9+1; g2 = 5,3,0 then (i%9)+1; g6 cell k = k%10.
    g1 = '0; g2 = '0; g6 = '0;
    for (int k = 0; k < N_CELLS; k++) begin
      g1[k*CELL_W +: CELL_W] = CELL_W'(k % 9 + 1);
      g6[k*CELL_W +: CELL_W] = CELL_W'(k % 10);
    end
    g2[0 +: CELL_W] = 4'd5;
    g2[4 +: CELL_W] = 4'd3;
    g2[8 +: CELL_W] = 4'd0;
    for (int i = 0; i < 78; i++) g2[(i+3)*CELL_W +: CELL_W] = CELL_W'(i % 9 + 1);

    repeat (3) @(negedge uart_sampling_clk);
    rst = 1'b0;
    @(negedge uart_sampling_clk);
    check("reset_grid",   ifc.grid, '0);
    check("reset_count",  GW'(ifc.cell_count), 0);
    check("reset_valid",  GW'(ifc.grid_valid), 0);
    check("reset_ferr",   GW'(ifc.frame_err), 0);
    check("reset_ovr",    GW'(ifc.overrun), 0);

    // 1: 81 digits "1".."9" repeated.
    grid_q.push_back(g1);
    for (int k = 0; k < N_CELLS; k++) begin
      if (k == N_CELLS - 1) check("t1_not_valid_before_last", GW'(ifc.grid_valid), 0);
      send(8'h31 + 8'(k % 9), 1);
    end
    check("t1_valid", GW'(ifc.grid_valid), 1);
    check("t1_cell0", GW'(ifc.grid[3:0]), 1);
    check("t1_cell80", GW'(ifc.grid[GW-1 -: CELL_W]), 9);

    // 4: overrun while full, then ack.
    ovr_q.push_back(g1);
    send(8'h34, 1);
    check("t4_count_held", GW'(ifc.cell_count), 81);
    check("t4_grid_held", ifc.grid, g1);
    ack();
    check("t4_valid_clear", GW'(ifc.grid_valid), 0);
    check("t4_count_clear", GW'(ifc.cell_count), 0);

    // 2: separators skipped, '.' is empty.
    grid_q.push_back(g2);
    send("5", 1); send(" ", 1); send("3", 1); send(" ", 1);
    send(".", 1); send(" ", 1); send(8'h0D, 1); send(8'h0A, 1);
    check("t2_count3", GW'(ifc.cell_count), 3);
    for (int i = 0; i < 78; i++) begin
      if (i == 77) begin
        check("t2_count80", GW'(ifc.cell_count), 80);
        check("t2_not_valid", GW'(ifc.grid_valid), 0);
      end
      send(8'h31 + 8'(i % 9), 1);
    end
    check("t2_cell2_empty", GW'(ifc.grid[11:8]), 0);
    // Strobe in the same cycle as grid_ack is still dropped.
    ovr_q.push_back(g2);
    @(negedge uart_sampling_clk);
    ifc.grid_ack = 1'b1; ifc.uart_byte = "6"; ifc.byte_ready = 1'b1;
    @(negedge uart_sampling_clk);
    ifc.grid_ack = 1'b0; ifc.byte_ready = 1'b0;
    @(negedge uart_sampling_clk);
    check("t2_ack_count", GW'(ifc.cell_count), 0);
    check("t2_ack_valid", GW'(ifc.grid_valid), 0);

    // 3: long byte_ready level counts once.
    send("7", 5);
    check("t3_one_cell", GW'(ifc.cell_count), 1);
    check("t3_cell0_7", GW'(ifc.grid[3:0]), 7);

    // 5: framing error after 10 digits; ack outside full ignored.
    for (int i = 0; i < 9; i++) send("2", 1);
    check("t5_count10", GW'(ifc.cell_count), 10);
    ack();
    check("t5_ack_ignored", GW'(ifc.cell_count), 10);
    send("x", 1);
    check("t5_ferr", GW'(ifc.frame_err), 1);
    check("t5_count0", GW'(ifc.cell_count), 0);
    send("5", 1);
    check("t5_digit_ignored", GW'(ifc.cell_count), 0);
    check("t5_ferr_held", GW'(ifc.frame_err), 1);
    send(8'h0A, 1);
    check("t5_ferr_clear", GW'(ifc.frame_err), 0);
    check("t5_count_after_lf", GW'(ifc.cell_count), 0);

    // 6: asynchronous reset mid-grid.
    for (int i = 0; i < 40; i++) send("8", 1);
    check("t6_count40", GW'(ifc.cell_count), 40);
    @(negedge uart_sampling_clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_grid", ifc.grid, '0);
    check("t6_async_count", GW'(ifc.cell_count), 0);
    @(negedge uart_sampling_clk);
    rst = 1'b0;
    grid_q.push_back(g6);
    for (int k = 0; k < N_CELLS; k++) send(8'h30 + 8'(k % 10), 1);
    check("t6_valid", GW'(ifc.grid_valid), 1);
    ack();
    @(negedge uart_sampling_clk);

    check("grid_queue_drained", GW'(grid_q.size()), 0);
    check("ovr_queue_drained", GW'(ovr_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
